// File: rtl/key_press_generator_if.sv
// key_press_generator_if
//   Command channel of the key press generator.
//   cmd_valid : command present (master -> slave)
//   cmd_ready : generator idle, command accepted when valid && ready (slave -> master)
//   cmd_key   : key index to pulse, 0 -> keys[0], 1 -> keys[1] (master -> slave)
//   cmd_count : number of presses, 0 is legal (master -> slave)
interface key_press_generator_if #(
  parameter int COUNT_W = 4
) ();
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_key;
  logic [COUNT_W-1:0] cmd_count;

  modport master (
    output cmd_valid,
    output cmd_key,
    output cmd_count,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_key,
    input  cmd_count,
    output cmd_ready
  );
endinterface

// File: rtl/key_press_generator.sv
// key_press_generator
//   Drives press/release waveforms on a two-key active-high interface.
//   A command (key index, press count) is taken over a valid/ready handshake;
//   the selected key is then pulsed count times, HOLD_CYCLES high followed by
//   GAP_CYCLES low per press.
//
//   clk          : clock, rising edge
//   rst          : asynchronous active-high reset
//   cmd          : command channel (slave side)
//   keys         : registered key drive, 1 = pressed, at most one bit high
//   busy         : command in progress (inverse of cmd.cmd_ready)
//   done         : one-cycle pulse when a command completes
//   presses_sent : completed presses of the current or last command
//
//   state | meaning
//   IDLE  | ready for a command, keys low
//   PRESS | selected key held high, hold timer running
//   GAP   | keys low after a press, gap timer running
module key_press_generator #(
  parameter int HOLD_CYCLES = 3,
  parameter int GAP_CYCLES  = 2,
  parameter int COUNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  key_press_generator_if.slave cmd,
  output logic [1:0]           keys,
  output logic                 busy,
  output logic                 done,
  output logic [COUNT_W-1:0]   presses_sent
);

  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  // Timers count down to zero, so a phase of L cycles loads L-1.
  localparam logic [TMR_W-1:0] HOLD_LD = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LD  = TMR_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [COUNT_W-1:0] remain_q, remain_d;
  logic [COUNT_W-1:0] presses_q, presses_d;
  logic               key_q, key_d;
  logic [1:0]         keys_q, keys_d;
  logic               done_q, done_d;
  logic               accept;

  function automatic logic [1:0] key_onehot(input logic k);
    return k ? 2'b10 : 2'b01;
  endfunction

  // Ready decodes the state register only, no path from cmd_valid.
  assign cmd.cmd_ready = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign accept        = cmd.cmd_valid && (state_q == IDLE);

  assign keys         = keys_q;
  assign done         = done_q;
  assign presses_sent = presses_q;

  // State register (also holds the datapath registers).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      tmr_q     <= '0;
      remain_q  <= '0;
      presses_q <= '0;
      key_q     <= 1'b0;
      keys_q    <= 2'b00;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      remain_q  <= remain_d;
      presses_q <= presses_d;
      key_q     <= key_d;
      keys_q    <= keys_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && (cmd.cmd_count != '0)) state_d = PRESS;
      PRESS:   if (tmr_q == '0) state_d = GAP;
      GAP:     if (tmr_q == '0) state_d = (remain_q != '0) ? PRESS : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath logic. keys_d/done_d are computed one cycle ahead so
  // the registered outputs line up with the state they belong to.
  always_comb begin
    tmr_d     = tmr_q;
    remain_d  = remain_q;
    presses_d = presses_q;
    key_d     = key_q;
    keys_d    = 2'b00;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          key_d     = cmd.cmd_key;
          remain_d  = cmd.cmd_count;
          presses_d = '0;
          if (cmd.cmd_count == '0) begin
            done_d = 1'b1;
          end else begin
            keys_d = key_onehot(cmd.cmd_key);
            tmr_d  = HOLD_LD;
          end
        end
      end
      PRESS: begin
        if (tmr_q == '0) begin
          presses_d = presses_q + 1'b1;
          remain_d  = remain_q - 1'b1;
          tmr_d     = GAP_LD;
        end else begin
          keys_d = key_onehot(key_q);
          tmr_d  = tmr_q - 1'b1;
        end
      end
      GAP: begin
        if (tmr_q == '0) begin
          if (remain_q != '0) begin
            keys_d = key_onehot(key_q);
            tmr_d  = HOLD_LD;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_key_press_generator.sv
// tb_key_press_generator
//   Directed stimulus for key_press_generator (HOLD=3, GAP=2, COUNT_W=4).
//   Each issued command pushes {key, count} to a scoreboard queue; a monitor
//   on the falling edge checks pulse placement, hold length, press counting
//   and done timing against the queue front.
module tb_key_press_generator;

  localparam int HOLD = 3;
  localparam int GAP  = 2;
  localparam int P    = HOLD + GAP;

  logic       clk;
  logic       rst;
  logic [1:0] keys;
  logic       busy;
  logic       done;
  logic [3:0] presses_sent;

  key_press_generator_if #(.COUNT_W(4)) cmd_if ();

  key_press_generator #(
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES (GAP),
    .COUNT_W    (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd         (cmd_if),
    .keys        (keys),
    .busy        (busy),
    .done        (done),
    .presses_sent(presses_sent)
  );

  typedef struct {
    logic       key;
    logic [3:0] count;
  } sb_t;

  sb_t sb_q[$];
  int  total = 0;
  int  bad   = 0;
  int  edge_n = 0;
  int  acc_edge = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Edge counter and accept-edge capture.
  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    if (!rst && cmd_if.cmd_valid && cmd_if.cmd_ready) acc_edge <= edge_n;
  end

  // Monitor / scoreboard.
  int         pidx = 0;
  int         rise_edge = 0;
  logic [1:0] keys_prev = 2'b00;

  always @(negedge clk) begin
    int cur;
    if (rst) begin
      sb_q.delete();
      pidx      = 0;
      keys_prev = 2'b00;
    end else begin
      cur = edge_n - 1;
      chk("busy_vs_ready", int'(busy), int'(!cmd_if.cmd_ready));
      if (keys == 2'b11) chk("keys_onehot", int'(keys), 1);
      for (int k = 0; k < 2; k++) begin
        if (keys[k] && !keys_prev[k]) begin
          if (sb_q.size() == 0) begin
            chk("rise_unexpected", k, -1);
          end else begin
            chk("rise_key", k, int'(sb_q[0].key));
            chk("rise_edge", cur, acc_edge + pidx * P);
            rise_edge = cur;
          end
        end
        if (!keys[k] && keys_prev[k]) begin
          chk("hold_len", cur - rise_edge, HOLD);
          chk("presses_at_fall", int'(presses_sent), pidx + 1);
          pidx++;
        end
      end
      if (done) begin
        if (sb_q.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          chk("done_edge", cur, acc_edge + int'(sb_q[0].count) * P);
          chk("done_presses", int'(presses_sent), int'(sb_q[0].count));
          chk("done_pulses", pidx, int'(sb_q[0].count));
          void'(sb_q.pop_front());
          pidx = 0;
        end
      end
      keys_prev = keys;
    end
  end

  // Waits for idle, presents the command, and drops valid after the accept edge.
  task automatic send(input logic k, input logic [3:0] n);
    int w = 0;
    @(negedge clk);
    while (!cmd_if.cmd_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) chk("ready_timeout", w, 0);
    #2;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_key   = k;
    cmd_if.cmd_count = n;
    sb_q.push_back('{key: k, count: n});
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_key   = ~k;
    cmd_if.cmd_count = 4'hF;
  endtask

  task automatic wait_done();
    int w = 0;
    while (sb_q.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300) begin
      chk("done_timeout", w, 0);
      sb_q.delete();
    end
  endtask

  initial begin
    int n;
    rst              = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_key   = 1'b0;
    cmd_if.cmd_count = 4'd0;

    // Reset asserted mid-cycle takes effect immediately.
    #3 rst = 1'b1;
    #1;
    chk("rst_keys", int'(keys), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_presses", int'(presses_sent), 0);
    chk("rst_ready", int'(cmd_if.cmd_ready), 1);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_keys", int'(keys), 0);
      chk("idle_ready", int'(cmd_if.cmd_ready), 1);
      chk("idle_done", int'(done), 0);
    end

    // Key1, two presses.
    send(1'b1, 4'd2);
    wait_done();
    chk("k1c2_presses", int'(presses_sent), 2);

    // Count 0: immediate done, presses cleared, ready never drops.
    send(1'b0, 4'd0);
    @(negedge clk);
    chk("c0_done", int'(done), 1);
    chk("c0_presses", int'(presses_sent), 0);
    chk("c0_ready", int'(cmd_if.cmd_ready), 1);
    chk("c0_keys", int'(keys), 0);
    repeat (2) begin
      @(negedge clk);
      chk("c0_done_low", int'(done), 0);
      chk("c0_ready_hold", int'(cmd_if.cmd_ready), 1);
    end

    // Busy and back-to-back: second command held valid while busy.
    send(1'b0, 4'd1);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_key   = 1'b1;
    cmd_if.cmd_count = 4'd3;
    sb_q.push_back('{key: 1'b1, count: 4'd3});
    n = 0;
    @(negedge clk);
    while (!cmd_if.cmd_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("b2b_busy_cycles", n, 5);
    chk("b2b_done_cycle", int'(done), 1);
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_count = 4'hF;
    wait_done();
    chk("b2b_presses", int'(presses_sent), 3);

    // Reset during the second press of a count=3 command.
    send(1'b0, 4'd3);
    repeat (6) @(negedge clk);
    chk("pre_rst_keys", int'(keys), 1);
    chk("pre_rst_presses", int'(presses_sent), 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_keys", int'(keys), 0);
    chk("mid_rst_presses", int'(presses_sent), 0);
    chk("mid_rst_ready", int'(cmd_if.cmd_ready), 1);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    send(1'b1, 4'd1);
    wait_done();
    chk("post_rst_presses", int'(presses_sent), 1);

    // Maximum count, no wrap.
    send(1'b0, 4'd15);
    wait_done();
    chk("max_presses", int'(presses_sent), 15);
    repeat (3) @(negedge clk);
    chk("max_hold_presses", int'(presses_sent), 15);
    chk("final_keys", int'(keys), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_press_generator.md
# key_press_generator

Hardware source of press/release waveforms on the two-key board interface, the drive side of what the key-driven counter consumes. It accepts a command (key index, press count) over a valid/ready handshake and drives `keys[1:0]` with active-high pulses of fixed hold and gap length. It replaces hand-timed bench stimulus and lets on-board self-test exercise the counter through its real key inputs.

## Interface
- `HOLD_CYCLES`, default 3: clock cycles a key stays high per press; must be ≥1.
- `GAP_CYCLES`, default 2: clock cycles a key stays low after each press; must be ≥1.
- `COUNT_W`, default 4: width of the press count and the progress counter.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: generator idle; a command is accepted on an edge where `cmd_valid && cmd_ready`.
- `cmd_key` in 1: key index to pulse (0 → `keys[0]`, 1 → `keys[1]`).
- `cmd_count` in `COUNT_W`: number of presses; 0 is legal.
- `keys` out 2: key drive, active-high (1 = pressed); registered.
- `busy` out 1: command in progress; equals `~cmd_ready`.
- `done` out 1: one-cycle pulse when a command completes.
- `presses_sent` out `COUNT_W`: completed presses of the current or last command.

## Operation
- FSM states: IDLE, PRESS, GAP.
- IDLE: `cmd_ready`=1 and `keys`=0.
  - On accept, capture `cmd_key` and `cmd_count` into internal registers, and clear `presses_sent` to 0.
  - If count=0: stay IDLE and pulse `done`.
  - Otherwise go to PRESS with the hold counter loaded.
- PRESS:
  - `keys[key]`=1; the other key bit is 0.
  - After `HOLD_CYCLES` cycles, go to GAP, increment `presses_sent`, and decrement the remaining count.
- GAP:
  - `keys`=0.
  - After `GAP_CYCLES` cycles: if remaining ≠0, go to PRESS; else go to IDLE and pulse `done`.
- A gap always follows the last press, so back-to-back commands never merge pulses.
- `cmd_valid` while busy is ignored. `cmd_key` and `cmd_count` are don't-care unless accepted.
- Only one key bit is ever high at a time. A key is never high in IDLE or GAP.
- `presses_sent` never wraps. Max count 2^COUNT_W−1 ends with `presses_sent` equal to that count.
- `presses_sent` holds its value after `done` until the next accept.
- Reset (asynchronous, any state) forces:
  - `keys`=0, `done`=0, `presses_sent`=0, internal counters 0, state IDLE.
  - `cmd_ready`=1 once reset is asserted. The first accept can occur on the first edge after `rst` deasserts.

## Timing
- Accept edge is E0. For count N≥1, with P = `HOLD_CYCLES` + `GAP_CYCLES`:
  - Press i (0-based) sets `keys[key]` at edge E0+i·P and clears it at edge E0+i·P+`HOLD_CYCLES`.
  - `presses_sent` becomes i+1 at that clearing edge.
  - `done` is set at edge E0+N·P and is high for exactly one cycle.
  - `cmd_ready` returns high at that same edge E0+N·P.
- Count 0: `done` is set at E0 and high for one cycle; `keys` stays 0; `busy` never asserts.
- Back-to-back: a command valid during the `done` cycle is accepted at edge E0+N·P+1; its first press starts at that edge.
- A command is accepted at most once per acceptance edge. `done` and accept can coincide only in the count-0 case.
- All outputs are registered except `cmd_ready`/`busy`, which decode the state register directly (no combinational path from inputs).

## Test plan
Scenarios 2–6 use HOLD_CYCLES=3 and GAP_CYCLES=2.
- Reset and idle: assert `rst` mid-cycle → immediately `keys`=00, `done`=0, `presses_sent`=0, `cmd_ready`=1; values stay stable with `cmd_valid`=0.
- Key1, count=2, accept at E0:
  - `keys`=10 during E0..E0+3, 00 during E0+3..E0+5, 10 during E0+5..E0+8, 00 afterward.
  - `done` is high only for the cycle after E0+10; `presses_sent`=2.
  - `keys[0]` is never 1.
- Key0, count=0 → `done` pulses for the cycle after E0; `keys` stays 00; `presses_sent`=0; `cmd_ready` never drops.
- Busy and back-to-back:
  - During a key0 count=1 command, hold `cmd_valid` high with key1 count=3 → ignored until the `done` cycle.
  - It is then accepted at E0+5+1; then three key1 pulses follow and `presses_sent` ends at 3.
- Reset mid-operation: assert `rst` during the second PRESS of a count=3 command → `keys`=00 asynchronously and `presses_sent`=0. After release, a new key1 count=1 command completes normally with `presses_sent`=1.
- Max count: key0, count=15 → 15 pulses, `done` at E0+75, `presses_sent`=15 (no wrap).
